// File: rtl/gate_exerciser_if.sv
// Signal bundle between a gate_exerciser and whatever launches sweeps and
// provides the gate-under-test output.
// slave  : the exerciser itself (drives the gate inputs, reports results)
// master : the launcher / gate side (drives start and y_in)
interface gate_exerciser_if #(
    parameter int N_IN = 2
);
    logic                 start;
    logic                 y_in;
    logic [N_IN-1:0]      vec_out;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [2**N_IN-1:0]   fail_vec;
    logic [N_IN:0]        err_count;

    modport master (
        output start,
        output y_in,
        input  vec_out,
        input  busy,
        input  done,
        input  pass,
        input  fail_vec,
        input  err_count
    );

    modport slave (
        input  start,
        input  y_in,
        output vec_out,
        output busy,
        output done,
        output pass,
        output fail_vec,
        output err_count
    );
endinterface

// File: rtl/gate_exerciser.sv
// On-chip truth-table walker for a combinational gate cell.
// Each input vector is held for SETTLE clocks, then y_in is sampled for one
// clock and compared with the matching EXPECT bit. Mismatches set the
// vector's bit in fail_vec and bump err_count. After the last vector the
// block parks in DONE with the results frozen until the next start.
module gate_exerciser #(
    parameter int                     N_IN   = 2,
    parameter logic [(1<<N_IN)-1:0]   EXPECT = 4'b1000,
    parameter int                     SETTLE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    gate_exerciser_if.slave    bus
);
    localparam int NV = 1 << N_IN;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE - 1);
    localparam logic [N_IN-1:0] VEC_LAST = '1;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        SAMPLE,
        DONE
    } state_t;

    state_t          state, state_nx;
    logic [N_IN-1:0] vec, vec_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [NV-1:0]   fv, fv_nx;
    logic [N_IN:0]   ec, ec_nx;

    // State and datapath registers; reset returns everything to zero at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            vec   <= '0;
            cnt   <= '0;
            fv    <= '0;
            ec    <= '0;
        end else begin
            state <= state_nx;
            vec   <= vec_nx;
            cnt   <= cnt_nx;
            fv    <= fv_nx;
            ec    <= ec_nx;
        end
    end

    // Next-state and datapath update for the sweep.
    always_comb begin
        state_nx = state;
        vec_nx   = vec;
        cnt_nx   = cnt;
        fv_nx    = fv;
        ec_nx    = ec;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_nx = HOLD;
                    vec_nx   = '0;
                    cnt_nx   = '0;
                    fv_nx    = '0;
                    ec_nx    = '0;
                end
            end
            HOLD: begin
                cnt_nx = cnt + CW'(1);
                if (cnt == CNT_LAST) begin
                    state_nx = SAMPLE;
                end
            end
            SAMPLE: begin
                if (bus.y_in != EXPECT[vec]) begin
                    fv_nx[vec] = 1'b1;
                    ec_nx      = ec + (N_IN+1)'(1);
                end
                if (vec == VEC_LAST) begin
                    state_nx = DONE;
                end else begin
                    vec_nx   = vec + N_IN'(1);
                    cnt_nx   = '0;
                    state_nx = HOLD;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Status outputs decode straight from state, so reset clears them
    // without waiting for a clock edge.
    assign bus.vec_out   = vec;
    assign bus.busy      = (state == HOLD) || (state == SAMPLE);
    assign bus.done      = (state == DONE);
    assign bus.pass      = (state == DONE) && (ec == '0);
    assign bus.fail_vec  = fv;
    assign bus.err_count = ec;
endmodule
